// File: rtl/bus_bridge_master_ctrl.sv
// Bridge-master node controller: buffers frames arriving from the UART
// receiver, replays each one on the local bus through a master port and
// returns read data (or an all-ones abort marker) over the UART transmitter.
module bus_bridge_master_ctrl #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int BB_ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-BB_ADDR_WIDTH-1:0] BB_PREFIX = '0,
  parameter int RD_TIMEOUT    = 1024,
  localparam int FW = DATA_WIDTH + BB_ADDR_WIDTH + 1,
  localparam int CW = $clog2(RD_TIMEOUT) + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  u_rx_ready,
  input  logic [FW-1:0]         u_dout,
  output logic [DATA_WIDTH-1:0] u_din,
  output logic                  u_en,
  input  logic                  u_tx_busy,
  output logic [ADDR_WIDTH-1:0] daddr,
  output logic [DATA_WIDTH-1:0] dwdata,
  output logic                  dmode,
  output logic                  dvalid,
  input  logic                  dready,
  input  logic [DATA_WIDTH-1:0] drdata,
  input  logic                  drvalid,
  output logic                  frame_drop,
  output logic                  rd_timeout,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_RD, TX_START, TX_GUARD} state_t;

  state_t        state;
  logic [FW-1:0] fifo_mem [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    count;
  logic [CW-1:0] tmo_cnt;
  logic [FW-1:0] head;
  logic          pop, push;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept
  // a frame while the FSM is taking the head.
  assign head = fifo_mem[rd_ptr];
  assign pop  = (state == IDLE) && (count != 2'd0);
  assign push = u_rx_ready && ((count != 2'd2) || pop);

  // Two-entry frame FIFO
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= u_dout;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

  // Status pulses and busy flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_drop <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_drop <= u_rx_ready && !push;
      busy       <= (state != IDLE) || (count != 2'd0);
    end
  end

  // Transaction FSM: one bus request at a time, read data forwarded to UART
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      daddr      <= '0;
      dwdata     <= '0;
      dmode      <= 1'b0;
      dvalid     <= 1'b0;
      u_din      <= '0;
      u_en       <= 1'b0;
      rd_timeout <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      u_en       <= 1'b0;
      rd_timeout <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          daddr  <= {BB_PREFIX, head[FW-2:DATA_WIDTH]};
          dwdata <= head[DATA_WIDTH-1:0];
          dmode  <= head[FW-1];
          dvalid <= 1'b1;
          state  <= REQ;
        end
        REQ: if (dready) begin
          dvalid  <= 1'b0;
          tmo_cnt <= '0;
          state   <= dmode ? IDLE : WAIT_RD;
        end
        WAIT_RD: begin
          if (drvalid) begin
            u_din <= drdata;
            state <= TX_START;
          end else if (tmo_cnt == CW'(RD_TIMEOUT - 1)) begin
            // Abort marker lets the remote bridge tell a dead read apart
            u_din      <= '1;
            rd_timeout <= 1'b1;
            state      <= TX_START;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        TX_START: if (!u_tx_busy) begin
          u_en  <= 1'b1;
          state <= TX_GUARD;
        end
        // UART raises busy a cycle after u_en; don't look at it until then
        TX_GUARD: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_bridge_master_ctrl.sv
// Self-checking bench for bus_bridge_master_ctrl (RD_TIMEOUT=16, prefix 4'h2).
module tb_bus_bridge_master_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        u_rx_ready = 1'b0;
  logic [20:0] u_dout = '0;
  logic [7:0]  u_din;
  logic        u_en;
  logic        u_tx_busy = 1'b0;
  logic [15:0] daddr;
  logic [7:0]  dwdata;
  logic        dmode;
  logic        dvalid;
  logic        dready = 1'b0;
  logic [7:0]  drdata = '0;
  logic        drvalid = 1'b0;
  logic        frame_drop;
  logic        rd_timeout;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // Monitor tallies
  int          en_cnt = 0, drop_cnt = 0, to_cnt = 0, dv_cnt = 0;
  logic [7:0]  en_din = '0;
  logic [24:0] got_q[$];

  bus_bridge_master_ctrl #(
    .ADDR_WIDTH(16), .DATA_WIDTH(8), .BB_ADDR_WIDTH(12),
    .BB_PREFIX(4'h2), .RD_TIMEOUT(16)
  ) dut (
    .clk(clk), .rstn(rstn), .u_rx_ready(u_rx_ready), .u_dout(u_dout),
    .u_din(u_din), .u_en(u_en), .u_tx_busy(u_tx_busy), .daddr(daddr),
    .dwdata(dwdata), .dmode(dmode), .dvalid(dvalid), .dready(dready),
    .drdata(drdata), .drvalid(drvalid), .frame_drop(frame_drop),
    .rd_timeout(rd_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (u_en) begin en_cnt++; en_din = u_din; end
    if (frame_drop) drop_cnt++;
    if (rd_timeout) to_cnt++;
    if (dvalid) dv_cnt++;
    if (dvalid && dready) got_q.push_back({dmode, daddr, dwdata});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] bus_addr(input logic [11:0] a);
    return 16'h2000 + {4'h0, a};
  endfunction

  task automatic send_frame(input logic m, input logic [11:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    u_rx_ready = 1'b1; u_dout = {m, a, d};
    @(posedge clk); #1;
    u_rx_ready = 1'b0;
  endtask

  task automatic wait_dvalid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dvalid) begin ok = 1'b1; break; end
    end
  endtask

  // Holds dready for exactly one sampling edge
  task automatic accept_req();
    @(posedge clk); #1; dready = 1'b1;
    @(posedge clk); #1; dready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({u_din, u_en, daddr, dwdata, dmode, dvalid, frame_drop, rd_timeout, busy} !== '0) begin
      errors++; $display("FAIL reset_outputs: got u_din=%h u_en=%b daddr=%h dwdata=%h dmode=%b dvalid=%b busy=%b, expected all zero",
                         u_din, u_en, daddr, dwdata, dmode, dvalid, busy);
    end
    @(posedge clk); #1; rstn = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({dvalid, u_en, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_idle: got dvalid=%b u_en=%b busy=%b, expected 000", dvalid, u_en, busy);
    end
  endtask

  task automatic test_write();
    int e0;
    e0 = en_cnt;
    send_frame(1'b1, 12'h123, 8'hA5);
    @(negedge clk);
    checks++;
    if (dvalid !== 1'b0) begin errors++; $display("FAIL wr_latency_early: dvalid=%b expected 0", dvalid); end
    @(negedge clk);
    checks++;
    if ({dvalid, dmode, daddr, dwdata} !== {1'b1, 1'b1, 16'h2123, 8'hA5}) begin
      errors++; $display("FAIL wr_request: dvalid=%b dmode=%b daddr=%h dwdata=%h expected 1 1 2123 a5", dvalid, dmode, daddr, dwdata);
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy: busy=%b expected 1", busy); end
    @(posedge clk); #1; dready = 1'b1;
    @(negedge clk);
    checks++;
    if ({dvalid, daddr, dwdata} !== {1'b1, 16'h2123, 8'hA5}) begin
      errors++; $display("FAIL wr_hold: dvalid=%b daddr=%h dwdata=%h expected 1 2123 a5", dvalid, daddr, dwdata);
    end
    @(posedge clk); #1; dready = 1'b0;
    @(negedge clk);
    checks++;
    if (dvalid !== 1'b0) begin errors++; $display("FAIL wr_release: dvalid=%b expected 0", dvalid); end
    // A stray drvalid while idle must not produce a UART send
    @(posedge clk); #1; drvalid = 1'b1; drdata = 8'h77;
    @(posedge clk); #1; drvalid = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (en_cnt !== e0) begin errors++; $display("FAIL wr_no_uen: u_en pulses=%0d expected 0", en_cnt - e0); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_clear: busy=%b expected 0", busy); end
  endtask

  task automatic test_read();
    bit ok;
    int e0;
    e0 = en_cnt;
    send_frame(1'b0, 12'h040, 8'($urandom));
    wait_dvalid(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rd_dvalid_timeout: dvalid never seen, expected request"); return; end
    checks++;
    if ({dmode, daddr} !== {1'b0, 16'h2040}) begin
      errors++; $display("FAIL rd_request: dmode=%b daddr=%h expected 0 2040", dmode, daddr);
    end
    accept_req();
    repeat (4) @(posedge clk);
    #1; drvalid = 1'b1; drdata = 8'h3C;
    @(posedge clk); #1; drvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (u_en !== 1'b0) begin errors++; $display("FAIL rd_uen_early: u_en=%b expected 0", u_en); end
    @(negedge clk);
    checks++;
    if ({u_en, u_din} !== {1'b1, 8'h3C}) begin
      errors++; $display("FAIL rd_uen: u_en=%b u_din=%h expected 1 3c", u_en, u_din);
    end
    @(negedge clk);
    checks++;
    if (u_en !== 1'b0) begin errors++; $display("FAIL rd_uen_pulse: u_en=%b expected 0", u_en); end
    repeat (4) @(negedge clk);
    checks++;
    if (en_cnt !== e0 + 1) begin errors++; $display("FAIL rd_uen_count: pulses=%0d expected 1", en_cnt - e0); end
  endtask

  task automatic test_drop();
    bit ok;
    logic [11:0] a[4];
    logic [7:0]  d[4];
    int d0, q0;
    for (int i = 0; i < 4; i++) begin a[i] = 12'($urandom); d[i] = 8'($urandom); end
    d0 = drop_cnt;
    q0 = got_q.size();
    send_frame(1'b1, a[0], d[0]);
    wait_dvalid(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL drop_dvalid_timeout: dvalid never seen, expected request"); return; end
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1; u_rx_ready = 1'b1; u_dout = {1'b1, a[i], d[i]};
    end
    @(posedge clk); #1; u_rx_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (drop_cnt !== d0 + 1) begin errors++; $display("FAIL drop_pulse: frame_drop pulses=%0d expected 1", drop_cnt - d0); end
    @(posedge clk); #1; dready = 1'b1;
    repeat (40) @(posedge clk);
    #1; dready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (got_q.size() !== q0 + 3) begin
      errors++; $display("FAIL drop_count: requests=%0d expected 3", got_q.size() - q0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[q0 + i] !== {1'b1, bus_addr(a[i]), d[i]}) begin
          errors++; $display("FAIL drop_order%0d: got %h expected %h", i, got_q[q0 + i], {1'b1, bus_addr(a[i]), d[i]});
        end
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int t0, e0;
    t0 = to_cnt; e0 = en_cnt;
    send_frame(1'b0, 12'($urandom), 8'($urandom));
    wait_dvalid(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL to_dvalid_timeout: dvalid never seen, expected request"); return; end
    accept_req();
    repeat (15) @(posedge clk);
    @(negedge clk);
    checks++;
    if (to_cnt !== t0) begin errors++; $display("FAIL to_early: rd_timeout pulses=%0d expected 0 after 15 cycles", to_cnt - t0); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rd_timeout, u_din} !== {1'b1, 8'hFF}) begin
      errors++; $display("FAIL to_pulse: rd_timeout=%b u_din=%h expected 1 ff", rd_timeout, u_din);
    end
    @(negedge clk);
    checks++;
    if (u_en !== 1'b1) begin errors++; $display("FAIL to_uen: u_en=%b expected 1", u_en); end
    repeat (5) @(negedge clk);
    checks++;
    if ({en_cnt - e0, to_cnt - t0, 32'(busy)} !== {32'd1, 32'd1, 32'd0}) begin
      errors++; $display("FAIL to_final: u_en pulses=%0d timeouts=%0d busy=%b expected 1 1 0", en_cnt - e0, to_cnt - t0, busy);
    end
  endtask

  task automatic test_tx_busy();
    bit ok;
    int e0;
    logic [7:0] rd;
    rd = 8'($urandom);
    e0 = en_cnt;
    u_tx_busy = 1'b1;
    send_frame(1'b0, 12'($urandom), 8'($urandom));
    wait_dvalid(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL txb_dvalid_timeout: dvalid never seen, expected request"); u_tx_busy = 1'b0; return; end
    accept_req();
    @(posedge clk); #1; drvalid = 1'b1; drdata = rd;
    @(posedge clk); #1; drvalid = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (en_cnt !== e0) begin errors++; $display("FAIL txb_held: u_en pulses=%0d expected 0 while busy", en_cnt - e0); end
    @(posedge clk); #1; u_tx_busy = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if ({en_cnt - e0, 24'd0, en_din} !== {32'd1, 24'd0, rd}) begin
      errors++; $display("FAIL txb_send: u_en pulses=%0d u_din=%h expected 1 %h", en_cnt - e0, en_din, rd);
    end
  endtask

  task automatic test_random();
    bit ok;
    logic        m;
    logic [11:0] a;
    logic [7:0]  d, rd;
    int e0, t0;
    for (int n = 0; n < 10; n++) begin
      m = 1'($urandom_range(0, 1)); a = 12'($urandom); d = 8'($urandom); rd = 8'($urandom);
      e0 = en_cnt; t0 = to_cnt;
      send_frame(m, a, d);
      wait_dvalid(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rnd%0d_dvalid_timeout: dvalid never seen, expected request", n); return; end
      checks++;
      if ({dmode, daddr} !== {m, bus_addr(a)} || (m && dwdata !== d)) begin
        errors++; $display("FAIL rnd%0d_req: dmode=%b daddr=%h dwdata=%h expected %b %h %h", n, dmode, daddr, dwdata, m, bus_addr(a), d);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      accept_req();
      if (!m) begin
        repeat ($urandom_range(0, 8)) @(posedge clk);
        #1; drvalid = 1'b1; drdata = rd;
        @(posedge clk); #1; drvalid = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({en_cnt - e0, to_cnt - t0, 24'd0, en_din} !== {32'd1, 32'd0, 24'd0, rd}) begin
          errors++; $display("FAIL rnd%0d_read: u_en pulses=%0d timeouts=%0d u_din=%h expected 1 0 %h", n, en_cnt - e0, to_cnt - t0, en_din, rd);
        end
      end else begin
        repeat (3) @(negedge clk);
        checks++;
        if (en_cnt !== e0) begin errors++; $display("FAIL rnd%0d_write_uen: pulses=%0d expected 0", n, en_cnt - e0); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int e0, dv0;
    send_frame(1'b0, 12'($urandom), 8'($urandom));
    wait_dvalid(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_dvalid_timeout: dvalid never seen, expected request"); return; end
    accept_req();
    send_frame(1'b1, 12'($urandom), 8'($urandom));
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy_before: busy=%b expected 1", busy); end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({u_din, u_en, daddr, dwdata, dmode, dvalid, frame_drop, rd_timeout, busy} !== '0) begin
      errors++; $display("FAIL rst_async: u_din=%h u_en=%b daddr=%h dwdata=%h dmode=%b dvalid=%b busy=%b expected all zero",
                         u_din, u_en, daddr, dwdata, dmode, dvalid, busy);
    end
    e0 = en_cnt; dv0 = dv_cnt;
    @(posedge clk); #1; rstn = 1'b1;
    @(posedge clk); #1; drvalid = 1'b1; drdata = 8'h5A;
    @(posedge clk); #1; drvalid = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if ({en_cnt - e0, dv_cnt - dv0, 32'(busy)} !== {32'd0, 32'd0, 32'd0}) begin
      errors++; $display("FAIL rst_quiet: u_en pulses=%0d dvalid cycles=%0d busy=%b expected 0 0 0", en_cnt - e0, dv_cnt - dv0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_drop();
    test_timeout();
    test_tx_busy();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
